// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_dec_pkg
// Purpose  : Shared widths, counts and FSM state encoding for the AES
//            decryption datapath (InvAddRoundKey column feeder and friends).
// Contents : AES_BLK_W    - width of one AES state / round key (128)
//            AES_COL_W    - width of one state column word (32)
//            AES_NUM_COLS - columns per state (4)
//            AES_RND_W    - width of the round index (4, rounds 0..14)
//            AES_IDX_W    - width of a column index (2)
//            fsm_state_e  - feeder FSM states (IDLE, SEND)
// Revision : 1.0 - initial release
// ============================================================================
package aes_dec_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int AES_COL_W    = 32;
  localparam int AES_NUM_COLS = 4;
  localparam int AES_RND_W    = 4;
  localparam int AES_IDX_W    = 2;

  // Feeder FSM: IDLE waits for a block, SEND streams its four columns.
  typedef enum logic [0:0] {
    FSM_IDLE = 1'b0,
    FSM_SEND = 1'b1
  } fsm_state_e;

  // Plain-vector views of the state encoding for code that keeps the state
  // register as logic rather than as the enum type.
  localparam logic [0:0] S_IDLE = FSM_IDLE;
  localparam logic [0:0] S_SEND = FSM_SEND;

endpackage : aes_dec_pkg
`default_nettype wire

// File: rtl/inv_add_round_key_feeder_if.sv
`default_nettype none
// ============================================================================
// Interface : inv_add_round_key_feeder_if
// Purpose   : Bundles the block-input handshake (InvSubBytes result plus
//             round key) and the column-output handshake toward the inverse
//             MixColumns stage.
// Signals   : in_valid/in_ready       - block handshake
//             in_state, in_key        - 128-bit state and round key
//             in_skip_mix, in_round   - final-round flag, round index
//             col_valid/col_ready     - column handshake
//             col_data, col_idx       - (state ^ key) column and its index
//             col_skip_mix, col_round - sideband carried with the block
//             col_last                - high on column 3
// Modports  : slave  - the feeder (consumes blocks, produces columns)
//             master - the environment around it
// Revision  : 1.0 - initial release
// ============================================================================
interface inv_add_round_key_feeder_if;
  import aes_dec_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_state;
  logic [AES_BLK_W-1:0] in_key;
  logic                 in_skip_mix;
  logic [AES_RND_W-1:0] in_round;

  logic                 col_valid;
  logic                 col_ready;
  logic [AES_COL_W-1:0] col_data;
  logic [AES_IDX_W-1:0] col_idx;
  logic                 col_skip_mix;
  logic [AES_RND_W-1:0] col_round;
  logic                 col_last;

  modport slave (
    input  in_valid, in_state, in_key, in_skip_mix, in_round, col_ready,
    output in_ready, col_valid, col_data, col_idx, col_skip_mix, col_round,
           col_last
  );

  modport master (
    output in_valid, in_state, in_key, in_skip_mix, in_round, col_ready,
    input  in_ready, col_valid, col_data, col_idx, col_skip_mix, col_round,
           col_last
  );

endinterface : inv_add_round_key_feeder_if
`default_nettype wire

// File: rtl/inv_add_round_key_feeder.sv
`default_nettype none
// ============================================================================
// Module   : inv_add_round_key_feeder
// Purpose  : Applies InvAddRoundKey (state XOR round key) to an accepted AES
//            block and streams the result one 32-bit column per cycle to the
//            downstream inverse MixColumns stage, with the round index and
//            final-round flag carried alongside every column.
// Params   : MSB_FIRST - 1: column 0 is state[127:96]; 0: column 0 is
//                        state[31:0]
// Ports    : clk  - rising-edge clock
//            rst  - synchronous, active-high reset
//            bus  - inv_add_round_key_feeder_if.slave (block in, columns out)
// Timing   : first column is valid the cycle after the block is accepted;
//            a new block may be accepted on the last-column handshake, so
//            continuous traffic sustains one block every four cycles.
// Revision : 1.0 - initial release
// ============================================================================
module inv_add_round_key_feeder
  import aes_dec_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  inv_add_round_key_feeder_if.slave   bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]           state_q, state_d;
  logic [AES_IDX_W-1:0] cnt_q,   cnt_d;
  logic [AES_BLK_W-1:0] blk_q,   blk_d;
  logic                 skip_q,  skip_d;
  logic [AES_RND_W-1:0] round_q, round_d;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic                 w_in_idle;
  logic                 w_in_send;
  logic                 w_last_col;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic                 w_col_fire;
  logic [AES_COL_W-1:0] w_col_word;

  always_comb begin
    w_in_idle  = (state_q == S_IDLE);
    w_in_send  = (state_q == S_SEND);
    w_last_col = (cnt_q == 2'd3);
    // A new block can slip in on the very cycle the last column leaves, so
    // in_ready looks straight through to col_ready in that case.
    w_in_ready = !rst && (w_in_idle || (w_in_send && w_last_col && bus.col_ready));
    w_in_fire  = bus.in_valid && w_in_ready;
    // col_ready only means something while a column is actually offered.
    w_col_fire = !rst && w_in_send && bus.col_ready;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    skip_d  = skip_q;
    round_d = round_q;

    if (w_in_fire) begin
      // Covers both the IDLE accept and the overlapped accept on the last
      // column handshake: either way the new block starts at column 0.
      state_d = S_SEND;
      cnt_d   = '0;
      blk_d   = bus.in_state ^ bus.in_key;
      skip_d  = bus.in_skip_mix;
      round_d = bus.in_round;
    end else if (w_col_fire) begin
      if (!w_last_col) begin
        cnt_d = cnt_q + 2'd1;
      end else begin
        // Park the counter at 0 so col_idx/col_data rest on column 0.
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      skip_q  <= 1'b0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      skip_q  <= skip_d;
      round_q <= round_d;
    end
  end

  // --------------------------------------------------------------------------
  // Column select. The mux is driven purely from registers, so the offered
  // column cannot change while the downstream stage stalls.
  // --------------------------------------------------------------------------
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      always_comb begin
        w_col_word = blk_q[127:96];
        case (cnt_q)
          2'd0:    w_col_word = blk_q[127:96];
          2'd1:    w_col_word = blk_q[95:64];
          2'd2:    w_col_word = blk_q[63:32];
          default: w_col_word = blk_q[31:0];
        endcase
      end
    end else begin : g_lsb_first
      always_comb begin
        w_col_word = blk_q[31:0];
        case (cnt_q)
          2'd0:    w_col_word = blk_q[31:0];
          2'd1:    w_col_word = blk_q[63:32];
          2'd2:    w_col_word = blk_q[95:64];
          default: w_col_word = blk_q[127:96];
        endcase
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready     = w_in_ready;
  assign bus.col_valid    = !rst && w_in_send;
  assign bus.col_data     = w_col_word;
  assign bus.col_idx      = cnt_q;
  assign bus.col_skip_mix = skip_q;
  assign bus.col_round    = round_q;
  assign bus.col_last     = w_in_send && w_last_col;

endmodule : inv_add_round_key_feeder
`default_nettype wire

// File: doc/inv_add_round_key_feeder.md
INV_ADD_ROUND_KEY_FEEDER -- requirements
Module: inv_add_round_key_feeder

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning column 0 = state[127:96] (1) or state[31:0] (0).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream block (InvSubBytes output + round key) valid.
REQ-005 SHALL have port in_ready  output  1  block accepted when in_valid & in_ready at clk edge.
REQ-006 SHALL have port in_state  input  128  AES state, FIPS-197 column-major byte order.
REQ-007 SHALL have port in_key  input  128  round key for this round.
REQ-008 SHALL have port in_skip_mix  input  1  final decryption round; downstream bypasses inverse MixColumns.
REQ-009 SHALL have port in_round  input  4  round index 0..14, passed through.
REQ-010 SHALL have port col_valid  output  1  column word valid to downstream inverse-MixColumns stage.
REQ-011 SHALL have port col_ready  input  1  downstream accepts column when col_valid & col_ready.
REQ-012 SHALL have port col_data  output  32  (state XOR key) column, byte 0 in [31:24].
REQ-013 SHALL have port col_idx  output  2  column index 0..3.
REQ-014 SHALL have ports col_skip_mix (1), col_round (4), col_last (1, high on column 3), all outputs.

Function
REQ-015 SHALL implement FSM states IDLE and SEND.
REQ-016 In IDLE, in_ready SHALL be 1 and col_valid SHALL be 0.
REQ-017 On accept, SHALL register blk = in_state XOR in_key, skip_mix, round; cnt = 0; next state SEND.
REQ-018 In SEND, col_valid SHALL be 1; col_data = column cnt of blk per MSB_FIRST; col_idx = cnt; col_last = (cnt == 3).
REQ-019 SHALL hold col_data, col_idx, col_skip_mix, col_round, col_last stable while col_valid & !col_ready.
REQ-020 On column handshake with cnt < 3, cnt SHALL increment by 1; cnt is 2 bits, never wraps in use.
REQ-021 On column handshake with cnt == 3, SHALL return to IDLE unless a new block is accepted the same cycle.
REQ-022 in_ready SHALL equal IDLE | (SEND & cnt == 3 & col_ready), combinational from col_ready.
REQ-023 On simultaneous last-column handshake and in accept, SHALL load the new block, cnt = 0, remain SEND; sustained throughput 4 cycles/block.
REQ-024 Latency: first column valid exactly 1 cycle after accept.
REQ-025 in_* values outside a handshake SHALL be ignored; col_ready outside SEND SHALL be ignored.

Reset
REQ-026 While rst is high at a clk edge: state = IDLE, cnt = 0, blk = 0, skip_mix = 0, round = 0.
REQ-027 While rst is high, in_ready and col_valid SHALL be 0; col_data, col_idx, col_skip_mix, col_round, col_last SHALL be 0 the cycle after.
REQ-028 Reset mid-block SHALL discard remaining columns; no partial block resumes.

Structure
REQ-029 Package aes_dec_pkg SHALL hold AES_BLK_W=128, AES_COL_W=32, AES_NUM_COLS=4, AES_RND_W=4 and the FSM state enum.
REQ-030 No sub-module; column select is a local mux, downstream inverse-MixColumns stage instantiated by parent.

Verification
REQ-031 Basic: state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, col_ready=1 -> col_data 00102030, 40506070, 8090a0b0, c0d0e0f0 on cycles 1..4, col_last on 4th.
REQ-032 Backpressure: same vectors, col_ready low 3 cycles on column 1 -> 40506070 held stable, in_ready 0, order preserved.
REQ-033 Back-to-back: two blocks, in_valid continuous, col_ready=1 -> 8 consecutive col_valid cycles, no bubble, second block round/skip_mix correct.
REQ-034 Final round: in_skip_mix=1, in_round=0 -> col_skip_mix=1, col_round=0 on all 4 columns.
REQ-035 Reset mid-block: rst after column 1 -> next cycle col_valid=0, in_ready=1 after rst drops, new block starts at col_idx 0.
REQ-036 MSB_FIRST=0: REQ-031 vectors -> first column c0d0e0f0, last 00102030.
